mode_select_debounce: RTL and testbench



---
 rtl/mode_select_debounce.sv | 147 ++++++++++++++
 tb/tb_mode_select_debounce.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mode_select_debounce.sv
// Display-mode input stage: synchronises and debounces an active-low pushbutton
// and toggles the registered binary/BCD mode bit once per accepted press.
module mode_select_debounce #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   CNT_W           = 20,
    parameter logic INIT_MODE       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    input  logic mode_load,
    input  logic mode_in,
    output logic mode,
    output logic toggle_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              sync1_r;
    logic              sync2_r;
    logic              pressed_s;
    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic              mode_r;
    logic              mode_s;
    logic              toggle_r;
    logic              toggle_s;
    logic              busy_r;

    // Counter stops at the last debounce count instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c >= CNT_LAST) begin
            r = CNT_LAST;
        end else begin
            r = c + CNT_ONE;
        end
        return r;
    endfunction

    assign pressed_s = ~sync2_r;

    // Two-flop synchroniser; resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    // Next-state, counter, mode and pulse decode.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        mode_s   = mode_r;
        toggle_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pressed_s) begin
                    state_s = PRESS_WAIT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s  = HELD;
                    cnt_s    = CNT_ZERO;
                    mode_s   = ~mode_r;
                    toggle_s = 1'b1;
                end else begin
                    cnt_s = sat_inc(cnt_r);
                end
            end
            HELD: begin
                if (!pressed_s) begin
                    state_s = RELEASE_WAIT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_s = HELD;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = sat_inc(cnt_r);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        // A load overrides the toggle, but the accepted press still pulses.
        if (mode_load) begin
            mode_s = mode_in;
        end else begin
            mode_s = mode_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            mode_r   <= INIT_MODE;
            toggle_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            mode_r   <= mode_s;
            toggle_r <= toggle_s;
            busy_r   <= (state_s != IDLE);
        end
    end

    assign mode         = mode_r;
    assign toggle_pulse = toggle_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_mode_select_debounce.sv
// Directed bench for mode_select_debounce with DEBOUNCE_CYCLES=4; a second
// instance built with INIT_MODE=1 checks the reset value.
module tb_mode_select_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_n = 1'b1;
    logic mode_load = 1'b0;
    logic mode_in = 1'b0;
    logic key1_n = 1'b1;
    logic load1 = 1'b0;
    logic in1 = 1'b0;
    logic mode, toggle_pulse, busy;
    logic mode1, toggle1, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mode_select_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .INIT_MODE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .mode_load(mode_load),
        .mode_in(mode_in), .mode(mode), .toggle_pulse(toggle_pulse), .busy(busy)
    );

    mode_select_debounce #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .INIT_MODE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .key_n(key1_n), .mode_load(load1),
        .mode_in(in1), .mode(mode1), .toggle_pulse(toggle1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        key_n = 1'b1;
        mode_load = 1'b0;
        mode_in = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        key_n = 1'b0;
        repeat (8) tick();
        checks++;
        if (mode !== 1'b1) begin errors++; $display("FAIL reset_pre_mode got %0b exp 1", mode); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mode !== 1'b0) begin errors++; $display("FAIL reset_mode got %0b exp 0", mode); end
        checks++;
        if (toggle_pulse !== 1'b0) begin errors++; $display("FAIL reset_toggle got %0b exp 0", toggle_pulse); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++;
        if (mode1 !== 1'b1) begin errors++; $display("FAIL reset_init1_mode got %0b exp 1", mode1); end
        key_n = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (mode1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("FAIL init1_after_reset got mode %0b busy %0b exp 1 0", mode1, busy1);
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        key_n = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            checks++;
            if (mode !== (n >= 7)) begin errors++; $display("FAIL press_mode edge %0d got %0b exp %0b", n, mode, (n >= 7)); end
            checks++;
            if (toggle_pulse !== (n == 7)) begin errors++; $display("FAIL press_pulse edge %0d got %0b exp %0b", n, toggle_pulse, (n == 7)); end
            checks++;
            if (busy !== (n >= 3)) begin errors++; $display("FAIL press_busy edge %0d got %0b exp %0b", n, busy, (n >= 3)); end
        end
        key_n = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            tick();
            checks++;
            if (busy !== (r < 7)) begin errors++; $display("FAIL release_busy edge %0d got %0b exp %0b", r, busy, (r < 7)); end
            checks++;
            if (mode !== 1'b1 || toggle_pulse !== 1'b0) begin
                errors++; $display("FAIL release_mode edge %0d got %0b/%0b exp 1/0", r, mode, toggle_pulse);
            end
        end
    endtask

    task automatic test_press_bounce();
        logic [15:0] pattern;
        do_reset();
        pattern = 16'b1111111111001000;  // bit i = key_n for edge i+1: low 3, high 1, low 2, high
        for (int n = 1; n <= 16; n++) begin
            key_n = pattern[n-1];
            tick();
            checks++;
            if (mode !== 1'b0 || toggle_pulse !== 1'b0) begin
                errors++; $display("FAIL press_bounce edge %0d got %0b/%0b exp 0/0", n, mode, toggle_pulse);
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL press_bounce_idle got %0b exp 0", busy); end
    endtask

    task automatic test_release_bounce();
        int pulses;
        logic [12:0] pattern;
        pulses = 0;
        do_reset();
        key_n = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (toggle_pulse === 1'b1) pulses++;
        end
        pattern = 13'b1111111111011;  // bit i = key_n for edge i+1: high 2, low 1, high 10
        for (int n = 1; n <= 13; n++) begin
            key_n = pattern[n-1];
            tick();
            if (toggle_pulse === 1'b1) pulses++;
            checks++;
            if (busy !== (n < 10)) begin errors++; $display("FAIL rel_bounce_busy edge %0d got %0b exp %0b", n, busy, (n < 10)); end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL rel_bounce_pulses got %0d exp 1", pulses); end
        checks++;
        if (mode !== 1'b1) begin errors++; $display("FAIL rel_bounce_mode got %0b exp 1", mode); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic prev;
        pulses = 0;
        prev = 1'b0;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            key_n = 1'b0;
            for (int n = 1; n <= 10; n++) begin
                tick();
                if (toggle_pulse === 1'b1) pulses++;
                checks++;
                if (prev === 1'b1 && toggle_pulse === 1'b1) begin
                    errors++; $display("FAIL b2b_double_pulse press %0d edge %0d got 1 exp 0", p, n);
                end
                prev = toggle_pulse;
            end
            checks++;
            if (mode !== (p == 0)) begin errors++; $display("FAIL b2b_mode press %0d got %0b exp %0b", p, mode, (p == 0)); end
            key_n = 1'b1;
            for (int n = 1; n <= 10; n++) begin
                tick();
                if (toggle_pulse === 1'b1) pulses++;
                prev = toggle_pulse;
            end
        end
        checks++;
        if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
    endtask

    task automatic test_load();
        do_reset();
        mode_load = 1'b1;
        mode_in = 1'b1;
        tick();
        mode_load = 1'b0;
        checks++;
        if (mode !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL load_idle got mode %0b busy %0b exp 1 0", mode, busy);
        end
        mode_load = 1'b1;
        mode_in = 1'b0;
        tick();
        mode_load = 1'b0;
        key_n = 1'b0;
        for (int n = 1; n <= 6; n++) tick();
        mode_load = 1'b1;
        mode_in = 1'b0;
        tick();
        mode_load = 1'b0;
        checks++;
        if (mode !== 1'b0) begin errors++; $display("FAIL load_collision_mode got %0b exp 0", mode); end
        checks++;
        if (toggle_pulse !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL load_collision_pulse got %0b busy %0b exp 1 1", toggle_pulse, busy);
        end
    endtask

    task automatic test_reset_mid_debounce();
        do_reset();
        key_n = 1'b0;
        for (int n = 1; n <= 5; n++) tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_reset_pre_busy got %0b exp 1", busy); end
        #2 rst_n = 1'b0;
        key_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || mode !== 1'b0) begin
            errors++; $display("FAIL mid_reset_async got busy %0b mode %0b exp 0 0", busy, mode);
        end
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            checks++;
            if (mode !== 1'b0 || toggle_pulse !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL mid_reset_after edge %0d got %0b/%0b/%0b exp 0/0/0", n, mode, toggle_pulse, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_back_to_back();
        test_load();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
